// File: rtl/write_buffer_pkg.sv
// Shared widths and drain-FSM state encoding for the posted-write buffer.
package write_buffer_pkg;
    localparam int WB_ADDR_W = 12;  // word address: tag + index
    localparam int WB_TAG_W  = 9;
    localparam int WB_IDX_W  = 3;
    localparam int WB_DATA_W = 32;
    localparam int WB_DEPTH  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } wb_state_e;
endpackage

// File: rtl/write_buffer_match_array.sv
// Per-entry address comparator: flags every valid entry whose address equals addr.
module wb_match_array
    import write_buffer_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
    input  logic [DEPTH-1:0]             entry_valid,
    input  logic [ADDR_W-1:0]            addr,
    output logic [DEPTH-1:0]             match
);
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign match[i] = entry_valid[i] && (entry_addr[i] == addr);
    end
endmodule

// File: rtl/write_buffer.sv
// Posted-write FIFO between the write-through cache and main memory.
// Merges writes into queued (not in-flight) entries and forwards pending
// data to reads so the fill path never sees stale memory.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int DEPTH  = WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  count
);
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0]             ent_valid;
    logic [PTR_W-1:0]             head, tail;
    wb_state_e                    state, state_next;

    logic [DEPTH-1:0] wr_match, rd_match, merge_cand;
    logic             push, pop, merge;
    logic [PTR_W-1:0] merge_idx, fwd_idx;
    logic [CNT_W-1:0] count_next;

    wb_match_array #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_merge_match (
        .entry_addr(ent_addr), .entry_valid(ent_valid), .addr(wr_addr), .match(wr_match)
    );

    wb_match_array #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd_match (
        .entry_addr(ent_addr), .entry_valid(ent_valid), .addr(rd_addr), .match(rd_match)
    );

    // Full refuses every write, merges included, so wr_ready never depends on the address.
    assign wr_ready   = (count != CNT_W'(DEPTH));
    assign push       = wr_valid && wr_ready;
    assign pop        = (state == REQ) && mem_ack;
    assign mem_req    = (state == REQ);
    assign mem_addr   = ent_addr[head];
    assign mem_data   = ent_data[head];
    assign count_next = count + CNT_W'(push && !merge) - CNT_W'(pop);

    // Merge target: any matching entry except the head while it is being drained.
    always_comb begin
        merge_cand = wr_match;
        if (state == REQ) merge_cand[head] = 1'b0;
        merge     = |merge_cand;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (merge_cand[i]) merge_idx = PTR_W'(i);
    end

    // Forwarding: walk from head towards tail so the youngest match wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PTR_W'(k);
            if (rd_match[fwd_idx]) begin
                rd_hit  = 1'b1;
                rd_data = ent_data[fwd_idx];
            end
        end
    end

    // Drain FSM next state: start on a non-empty buffer, stop once it empties.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = REQ;
            REQ:     state_next = (count_next != '0) ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Entry storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_addr  <= '0;
            ent_data  <= '0;
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            if (push) begin
                if (merge) begin
                    ent_data[merge_idx] <= wr_data;
                end else begin
                    ent_addr[tail]  <= wr_addr;
                    ent_data[tail]  <= wr_data;
                    ent_valid[tail] <= 1'b1;
                    tail            <= tail + 1'b1;
                end
            end
            count <= count_next;
        end
    end
endmodule

// File: tb/tb_write_buffer.sv
// Randomized and directed bench for write_buffer against a queue-based model.
module tb_write_buffer;
    import write_buffer_pkg::*;

    localparam int DEPTH = WB_DEPTH;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [11:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [11:0] rd_addr = '0;
    logic        rd_hit;
    logic [31:0] rd_data;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ack = 1'b0;
    logic [2:0]  count;

    write_buffer dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .count(count)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    ent_t mq[$];   // model contents, oldest first
    logic m_req = 1'b0;
    ent_t dq[$];   // writes observed leaving the DUT

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at negedge with inputs set: check outputs, take the edge, update model.
    task automatic step();
        logic        hit;
        logic [31:0] d;
        int          j;
        logic        nonempty;
        ent_t        tmp;
        #1;
        hit = 1'b0;
        d   = '0;
        foreach (mq[i]) if (mq[i].a == rd_addr) begin hit = 1'b1; d = mq[i].d; end
        chk("wr_ready", wr_ready, mq.size() != DEPTH);
        chk("count", count, mq.size());
        chk("mem_req", mem_req, m_req);
        if (m_req) begin
            chk("mem_addr", mem_addr, mq[0].a);
            chk("mem_data", mem_data, mq[0].d);
        end
        chk("rd_hit", rd_hit, hit);
        chk("rd_data", rd_data, d);
        if (mem_req && mem_ack) dq.push_back('{mem_addr, mem_data});
        @(posedge clk);
        nonempty = (mq.size() != 0);
        if (wr_valid && mq.size() != DEPTH) begin
            j = -1;
            for (int i = (m_req ? 1 : 0); i < mq.size(); i++)
                if (mq[i].a == wr_addr) j = i;
            if (j >= 0) mq[j].d = wr_data;
            else        mq.push_back('{wr_addr, wr_data});
        end
        if (m_req && mem_ack) tmp = mq.pop_front();
        m_req = m_req ? (mq.size() != 0) : nonempty;
        @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic ack);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; mem_ack = ack;
        step();
    endtask

    task automatic idle(input logic ack);
        wr_valid = 1'b0; mem_ack = ack;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (mq.size() != 0 || m_req); i++) idle(1'b1);
        mem_ack = 1'b0;
        #1;
        chk("drain_empty", count, 0);
        chk("drain_req", mem_req, 0);
    endtask

    task automatic chk_dq(input string tag, input int idx, input logic [11:0] a, input logic [31:0] d);
        chk({tag, "_n"}, dq.size() > idx, 1'b1);
        if (dq.size() > idx) begin
            chk({tag, "_a"}, dq[idx].a, a);
            chk({tag, "_d"}, dq[idx].d, d);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        chk("rst_ready", wr_ready, 1);
        chk("rst_req", mem_req, 0);
        chk("rst_hit", rd_hit, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_count", count, 0);
        reset = 1'b0;
        @(negedge clk);

        // Fill and stall with no acks
        dq.delete();
        for (int i = 0; i < 4; i++) wr(12'h010 + 12'(i), 32'h100 + 32'(i), 1'b0);
        wr(12'h014, 32'h114, 1'b0);
        #1;
        chk("stall_cnt", count, 4);
        chk("stall_ready", wr_ready, 0);
        idle(1'b1);
        #1;
        chk("stall_next", mem_addr, 12'h011);
        wr(12'h014, 32'h114, 1'b0);
        drain();
        chk_dq("fill0", 0, 12'h010, 32'h100);
        chk_dq("fill1", 1, 12'h011, 32'h101);
        chk_dq("fill4", 4, 12'h014, 32'h114);

        // Merge into a queued entry behind an in-flight head
        dq.delete();
        wr(12'h020, 32'hAAAA, 1'b0);
        idle(1'b0);
        wr(12'h021, 32'hBBBB, 1'b0);
        wr(12'h021, 32'hCCCC, 1'b0);
        #1;
        chk("merge_cnt", count, 2);
        drain();
        chk("merge_len", dq.size(), 2);
        chk_dq("merge0", 0, 12'h020, 32'hAAAA);
        chk_dq("merge1", 1, 12'h021, 32'hCCCC);

        // Same address as the in-flight head must append
        dq.delete();
        wr(12'h030, 32'h1, 1'b0);
        idle(1'b0);
        rd_addr = 12'h030;
        wr(12'h030, 32'h2, 1'b0);
        #1;
        chk("nomerge_cnt", count, 2);
        chk("nomerge_fwd", rd_data, 32'h2);
        drain();
        chk_dq("nomerge0", 0, 12'h030, 32'h1);
        chk_dq("nomerge1", 1, 12'h030, 32'h2);

        // Push and ack together at count 2, then enough traffic to wrap pointers
        wr(12'h040, 32'h40, 1'b0);
        wr(12'h041, 32'h41, 1'b0);
        wr(12'h042, 32'h42, 1'b1);
        #1;
        chk("pushack_cnt", count, 2);
        for (int i = 0; i < 9; i++) wr(12'h080 + 12'(i), 32'h80 + 32'(i), 1'(i % 2));
        drain();

        // Back-to-back acks from a full buffer
        for (int i = 0; i < 4; i++) wr(12'h090 + 12'(i), 32'h90 + 32'(i), 1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("b2b_req", mem_req, 1);
            idle(1'b1);
        end
        #1;
        chk("b2b_done", mem_req, 0);
        mem_ack = 1'b0;

        // Async reset while draining three entries
        for (int i = 0; i < 3; i++) wr(12'h050 + 12'(i), 32'h50 + 32'(i), 1'b0);
        idle(1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_cnt", count, 0);
        chk("midrst_ready", wr_ready, 1);
        for (int i = 0; i < 3; i++) begin
            rd_addr = 12'h050 + 12'(i);
            #1;
            chk("midrst_hit", rd_hit, 0);
        end
        mq.delete();
        m_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Random traffic on a small address pool to exercise merges and forwarding
        for (int c = 0; c < 400; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 12'h060 + 12'($urandom_range(0, 5));
            wr_data  = $urandom;
            mem_ack  = ($urandom_range(0, 2) == 0);
            rd_addr  = 12'h060 + 12'($urandom_range(0, 6));
            step();
        end
        wr_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
